// File: rtl/prbs4_checker.sv
// Serial PRBS-4 (x^4 + x^3 + 1) stream checker.
// Self-synchronises, locks, then counts errors against a free-running reference.
module prbs4_checker #(
    parameter int LOCK_THRESH   = 8,
    parameter int UNLOCK_THRESH = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [3:0] LT = 4'(LOCK_THRESH);
    localparam logic [3:0] UT = 4'(UNLOCK_THRESH);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t           state, state_n;
    logic [3:0]       h, h_n;
    logic [2:0]       fill, fill_n;
    logic [3:0]       mc, mc_n;
    logic [3:0]       ce, ce_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pulse, pulse_n;
    logic             exp_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
            h     <= '0;
            fill  <= '0;
            mc    <= '0;
            ce    <= '0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_n;
            h     <= h_n;
            fill  <= fill_n;
            mc    <= mc_n;
            ce    <= ce_n;
            cnt   <= cnt_n;
            pulse <= pulse_n;
        end
    end

    always_comb begin
        state_n = state;
        h_n     = h;
        fill_n  = fill;
        mc_n    = mc;
        ce_n    = ce;
        cnt_n   = cnt;
        pulse_n = 1'b0;
        exp_bit = h[0] ^ h[3];

        if (din_valid) begin
            case (state)
                SEARCH: begin
                    h_n = {h[2:0], din};
                    if (fill < 3'd4) begin
                        fill_n = fill + 3'd1;
                    end else if ((din == exp_bit) && (h != 4'b0000)) begin
                        if (mc + 4'd1 == LT) begin
                            state_n = LOCKED;
                            mc_n    = '0;
                            ce_n    = '0;
                        end else begin
                            mc_n = mc + 4'd1;
                        end
                    end else begin
                        mc_n = '0;
                    end
                end
                LOCKED: begin
                    // Reference feeds back on itself so a corrupted bit never enters history
                    h_n = {h[2:0], exp_bit};
                    if (din == exp_bit) begin
                        ce_n = '0;
                    end else begin
                        pulse_n = 1'b1;
                        if (cnt != '1) begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                        if (ce + 4'd1 == UT) begin
                            state_n = SEARCH;
                            fill_n  = '0;
                            mc_n    = '0;
                            ce_n    = '0;
                            h_n     = '0;
                        end else begin
                            ce_n = ce + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (clear_cnt) begin
            cnt_n = '0;
        end
    end

    assign locked    = (state == LOCKED);
    assign err_pulse = pulse;
    assign err_cnt   = cnt;

endmodule
